alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one 18-bit ALU (registered, clocked on clk) between two requesters.
- Round-robin arbitration; accepts one operation at a time, holds operands and opcode stable on the ALU for a per-op latency, then captures result and flags.
- Returns the captured result through a valid/ready response port tagged with the requester id.
- Sits between the instruction front-end/DMA requesters and the ALU instance.

Parameters:
- W, 18, datapath width (operands, result).
- ADD_LAT, 1, cycles from issue to result capture for add/sub (>=1).
- MUL_LAT, 2, cycles for mult (>=1).
- DIV_LAT, 4, cycles for div (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- s0_valid  in  1  requester 0 has an op.
- s0_ready  out  1  requester 0 op accepted this cycle.
- s0_a, s0_b  in  W  requester 0 operands.
- s0_op  in  4  requester 0 opcode: 0000 add, 0001 sub, 0010 mult, 0011 div.
- s1_valid, s1_ready, s1_a, s1_b, s1_op  same as requester 0, for requester 1.
- alu_datA, alu_datB  out  W  ALU operands.
- alu_ctrl  out  4  ALU opcode.
- alu_result  in  W  ALU result.
- alu_ovf, alu_agtb, alu_n, alu_z  in  1 each  ALU flags.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester that issued the op.
- rsp_result  out  W  captured result.
- rsp_flags  out  4  {ovf, agtb, n, z}.
- rsp_err  out  1  illegal opcode (or trapped div-by-0).
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, EXEC, RESP.
- Reset (rst_n=0 at clk edge), from any state: state=IDLE, rr pointer=0 (s0 preferred), all outputs 0 (alu_* 0, rsp_* 0, busy 0). An in-flight op or pending response is dropped silently.
- Arbitration in IDLE:
  - grant = pointer if that side is valid, else the other side if valid.
  - sX_ready = (state==IDLE) & grant==X, combinational. At most one ready per cycle; never ready outside IDLE.
- Accept (valid&ready edge):
  - Latch a, b, op, id.
  - Legal op: alu_datA/alu_datB/alu_ctrl driven from registers starting the next cycle; cnt loaded with LAT(op); go EXEC.
  - Illegal op (0100-1111): ALU not issued (alu_* unchanged); rsp_err=1, rsp_result=0, rsp_flags=0; go RESP directly.
- EXEC:
  - alu_* held constant; cnt decrements each cycle.
  - On the edge where cnt==1, capture alu_result and flags into rsp_*, rsp_err=0, go RESP.
  - rsp_valid rises exactly LAT(op) cycles after the accept edge.
- RESP:
  - rsp_valid=1; all rsp_* stable until rsp_ready.
  - On valid&ready edge: rsp_valid=0, pointer = ~rsp_id, go IDLE.
  - A new op can be accepted no earlier than the cycle after the response handshake, i.e. no overlap.
- alu_* keep their last values in IDLE/RESP; no glitching to 0.
- Fairness: both requesters continuously valid -> grants alternate 0,1,0,1.
- Back-pressure: rsp_ready held low stalls in RESP indefinitely; both s*_ready stay low.
- Width: no widening; result and flags are exactly what the ALU produces; the arbiter does no arithmetic.

Optional Feature:
- Macro ALU_ARB_DIV0_TRAP_EN.
- Defined: a div op accepted with b==0 is not issued; goes straight to RESP with rsp_err=1, rsp_result=0, rsp_flags=0, response one cycle after accept.
- Undefined: div-by-0 issued to the ALU like any div; response carries whatever the ALU returns, rsp_err=0.

Decomposition:
- Package alu_arb_pkg: opcode constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV), state enum, flag bit indices, function returning latency per opcode.
- One sub-module, rr_arb2: 2-way round-robin grant from valids + pointer, combinational.

Test Plan:
- s0: a=14, b=29, op=0001 (ALU stub: registered, 1 cycle) -> s0_ready 1 cycle; rsp_valid ADD_LAT=1 cycle later; rsp_id=0, rsp_result=18'h3FFF1, flags n=1, z=0, agtb=0, ovf=0.
- s0 and s1 both valid from reset with add ops (3+4, 5+6), rsp_ready=1 -> grant order 0,1,0,1; results 7, 11 alternating.
- s1 op=0010, a=6, b=7, rsp_ready low 5 cycles -> rsp_valid after 2 cycles, held with result 42 stable; no s*_ready during stall; accepted after ready.
- s0 op=0111 -> no ALU change, rsp_err=1, rsp_result=0, response the cycle after accept.
- s0 div a=100, b=0, with/without ALU_ARB_DIV0_TRAP_EN -> err=1 after 1 cycle vs ALU output after 4 cycles.
- rst_n low during EXEC of a div -> next cycle IDLE, busy=0, rsp_valid=0, pointer=0; next op accepted normally.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
// Provides opcode encodings, FSM state type, response flag bit positions,
// counter width, and helpers for opcode legality and per-opcode latency.
package alu_arb_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned CNT_W = 8;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_MUL = 4'b0010;
  localparam logic [OP_W-1:0] OP_DIV = 4'b0011;

  // Bit positions inside rsp_flags = {ovf, agtb, n, z}
  localparam int unsigned FLAG_OVF  = 3;
  localparam int unsigned FLAG_AGTB = 2;
  localparam int unsigned FLAG_N    = 1;
  localparam int unsigned FLAG_Z    = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Only the four low encodings are implemented by the ALU.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op[3:2] == 2'b00);
  endfunction

  // Cycles from accept to result capture for a legal opcode.
  function automatic logic [CNT_W-1:0] op_latency(input logic [OP_W-1:0] op,
                                                  input int unsigned add_lat,
                                                  input int unsigned mul_lat,
                                                  input int unsigned div_lat);
    case (op)
      OP_MUL:  return CNT_W'(mul_lat);
      OP_DIV:  return CNT_W'(div_lat);
      default: return CNT_W'(add_lat);
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// Ports: req0/req1 request valids, ptr preferred side,
//        gnt_valid_c some request granted, gnt_id_c granted side.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic gnt_valid_c,
  output logic gnt_id_c
);

  // Preferred side wins if it is requesting, otherwise the other side.
  always_comb begin
    gnt_valid_c = req0 | req1;
    if (ptr) gnt_id_c = req1 ? 1'b1 : 1'b0;
    else     gnt_id_c = req0 ? 1'b0 : 1'b1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters with round-robin arbitration.
// One op in flight at a time: operands/opcode are held on the ALU bus for the
// op's latency, then result and flags are captured and returned through a
// valid/ready response port tagged with the requester id.
// Ports: clk, rst_n (sync, active low); s0_*/s1_* request channels
// (valid, ready, a, b, op); alu_datA/alu_datB/alu_ctrl to the ALU;
// alu_result/alu_ovf/alu_agtb/alu_n/alu_z from the ALU; rsp_valid/rsp_ready,
// rsp_id, rsp_result, rsp_flags {ovf,agtb,n,z}, rsp_err; busy (not IDLE).
// Build option: ALU_ARB_DIV0_TRAP_EN traps div with b==0 as an error response
// instead of issuing it to the ALU.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned W       = 18,
  parameter int unsigned ADD_LAT = 1,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s0_valid,
  output logic          s0_ready,
  input  logic [W-1:0]  s0_a,
  input  logic [W-1:0]  s0_b,
  input  logic [3:0]    s0_op,
  input  logic          s1_valid,
  output logic          s1_ready,
  input  logic [W-1:0]  s1_a,
  input  logic [W-1:0]  s1_b,
  input  logic [3:0]    s1_op,
  output logic [W-1:0]  alu_datA,
  output logic [W-1:0]  alu_datB,
  output logic [3:0]    alu_ctrl,
  input  logic [W-1:0]  alu_result,
  input  logic          alu_ovf,
  input  logic          alu_agtb,
  input  logic          alu_n,
  input  logic          alu_z,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [W-1:0]  rsp_result,
  output logic [3:0]    rsp_flags,
  output logic          rsp_err,
  output logic          busy
);

  state_t           state, state_nxt;
  logic             ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             id_q, id_nxt;
  logic [W-1:0]     alu_a_nxt, alu_b_nxt;
  logic [3:0]       alu_op_nxt;
  logic             rsp_valid_nxt, rsp_id_nxt, rsp_err_nxt;
  logic [W-1:0]     rsp_result_nxt;
  logic [3:0]       rsp_flags_nxt;

  logic             gnt_valid_c, gnt_id_c;
  logic [W-1:0]     sel_a_c, sel_b_c;
  logic [3:0]       sel_op_c;
  logic             div0_trap_c;
  logic [3:0]       alu_flags_c;

  rr_arb2 u_rr (
    .req0        (s0_valid),
    .req1        (s1_valid),
    .ptr         (ptr),
    .gnt_valid_c (gnt_valid_c),
    .gnt_id_c    (gnt_id_c)
  );

  // Request payload of the granted side
  assign sel_a_c  = gnt_id_c ? s1_a  : s0_a;
  assign sel_b_c  = gnt_id_c ? s1_b  : s0_b;
  assign sel_op_c = gnt_id_c ? s1_op : s0_op;

`ifdef ALU_ARB_DIV0_TRAP_EN
  assign div0_trap_c = (sel_op_c == OP_DIV) && (sel_b_c == '0);
`else
  assign div0_trap_c = 1'b0;
`endif

  always_comb begin
    alu_flags_c            = '0;
    alu_flags_c[FLAG_OVF]  = alu_ovf;
    alu_flags_c[FLAG_AGTB] = alu_agtb;
    alu_flags_c[FLAG_N]    = alu_n;
    alu_flags_c[FLAG_Z]    = alu_z;
  end

  // Next-state and output decode
  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    cnt_nxt        = cnt;
    id_nxt         = id_q;
    alu_a_nxt      = alu_datA;
    alu_b_nxt      = alu_datB;
    alu_op_nxt     = alu_ctrl;
    rsp_valid_nxt  = rsp_valid;
    rsp_id_nxt     = rsp_id;
    rsp_result_nxt = rsp_result;
    rsp_flags_nxt  = rsp_flags;
    rsp_err_nxt    = rsp_err;
    s0_ready       = 1'b0;
    s1_ready       = 1'b0;

    case (state)
      S_IDLE: begin
        if (gnt_valid_c) begin
          s0_ready = ~gnt_id_c;
          s1_ready = gnt_id_c;
          id_nxt   = gnt_id_c;
          if (op_legal(sel_op_c) && !div0_trap_c) begin
            alu_a_nxt  = sel_a_c;
            alu_b_nxt  = sel_b_c;
            alu_op_nxt = sel_op_c;
            cnt_nxt    = op_latency(sel_op_c, ADD_LAT, MUL_LAT, DIV_LAT);
            state_nxt  = S_EXEC;
          end else begin
            // Rejected op: ALU bus untouched, error response right away
            rsp_valid_nxt  = 1'b1;
            rsp_id_nxt     = gnt_id_c;
            rsp_result_nxt = '0;
            rsp_flags_nxt  = '0;
            rsp_err_nxt    = 1'b1;
            state_nxt      = S_RESP;
          end
        end
      end
      S_EXEC: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          rsp_valid_nxt  = 1'b1;
          rsp_id_nxt     = id_q;
          rsp_result_nxt = alu_result;
          rsp_flags_nxt  = alu_flags_c;
          rsp_err_nxt    = 1'b0;
          state_nxt      = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          ptr_nxt       = ~rsp_id;
          state_nxt     = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ptr        <= 1'b0;
      cnt        <= '0;
      id_q       <= 1'b0;
      alu_datA   <= '0;
      alu_datB   <= '0;
      alu_ctrl   <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      cnt        <= cnt_nxt;
      id_q       <= id_nxt;
      alu_datA   <= alu_a_nxt;
      alu_datB   <= alu_b_nxt;
      alu_ctrl   <= alu_op_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_id     <= rsp_id_nxt;
      rsp_result <= rsp_result_nxt;
      rsp_flags  <= rsp_flags_nxt;
      rsp_err    <= rsp_err_nxt;
      busy       <= (state_nxt != S_IDLE);
    end
  end

endmodule
